// File: rtl/alu_pkg.sv
// Shared opcodes, FSM state encodings and opcode width for the multi-cycle ALU.
package alu_pkg;

    localparam int OP_WIDTH = 4;

    localparam logic [OP_WIDTH-1:0] ALU_ADD  = 4'd0;
    localparam logic [OP_WIDTH-1:0] ALU_SUB  = 4'd1;
    localparam logic [OP_WIDTH-1:0] ALU_AND  = 4'd2;
    localparam logic [OP_WIDTH-1:0] ALU_OR   = 4'd3;
    localparam logic [OP_WIDTH-1:0] ALU_XOR  = 4'd4;
    localparam logic [OP_WIDTH-1:0] ALU_SLT  = 4'd5;
    localparam logic [OP_WIDTH-1:0] ALU_SLTU = 4'd6;
    localparam logic [OP_WIDTH-1:0] ALU_SLL  = 4'd7;
    localparam logic [OP_WIDTH-1:0] ALU_SRL  = 4'd8;
    localparam logic [OP_WIDTH-1:0] ALU_SRA  = 4'd9;
    localparam logic [OP_WIDTH-1:0] ALU_MUL  = 4'd10;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/alu_mc_comb.sv
// Single-cycle ALU results and overflow; ALU_MC_SAT_EN makes ADD/SUB saturate on overflow.
module alu_mc_comb
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int OP_WIDTH    = 4,
    parameter int SHAMT_WIDTH = $clog2(DATA_WIDTH)
) (
    input  logic [OP_WIDTH-1:0]   op,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  overflow
);

    localparam logic [DATA_WIDTH-1:0] MAX_POS = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] MIN_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    logic                   is_sub;
    logic [DATA_WIDTH-1:0]  b_eff;
    logic [DATA_WIDTH-1:0]  sum;
    logic                   add_ovf;
    logic [SHAMT_WIDTH-1:0] shamt;

    // SUB reuses the adder as a + ~b + 1
    assign is_sub  = (op == ALU_SUB);
    assign b_eff   = is_sub ? ~b : b;
    assign sum     = a + b_eff + {{(DATA_WIDTH-1){1'b0}}, is_sub};
    assign add_ovf = (a[DATA_WIDTH-1] == b_eff[DATA_WIDTH-1]) &&
                     (sum[DATA_WIDTH-1] != a[DATA_WIDTH-1]);
    assign shamt   = b[SHAMT_WIDTH-1:0];

    always_comb begin
        result   = '0;
        overflow = 1'b0;
        case (op)
            ALU_ADD, ALU_SUB: begin
                overflow = add_ovf;
`ifdef ALU_MC_SAT_EN
                if (add_ovf)
                    result = a[DATA_WIDTH-1] ? MIN_NEG : MAX_POS;
                else
                    result = sum;
`else
                result = sum;
`endif
            end
            ALU_AND:  result = a & b;
            ALU_OR:   result = a | b;
            ALU_XOR:  result = a ^ b;
            ALU_SLT:  result = {{(DATA_WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_SLTU: result = {{(DATA_WIDTH-1){1'b0}}, (a < b)};
            ALU_SLL:  result = a << shamt;
            ALU_SRL:  result = a >> shamt;
            ALU_SRA:  result = $unsigned($signed(a) >>> shamt);
            default:  result = '0;
        endcase
    end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU top: handshake FSM, result registers and shift-add multiplier.
// ALU_MC_SAT_EN makes MUL saturate to all-ones when the high product half is non-zero.
module alu_mc
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int OP_WIDTH    = 4,
    parameter int SHAMT_WIDTH = $clog2(DATA_WIDTH)
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_in_valid,
    output logic                  o_in_ready,
    input  logic [OP_WIDTH-1:0]   i_op,
    input  logic [DATA_WIDTH-1:0] i_data_a,
    input  logic [DATA_WIDTH-1:0] i_data_b,
    output logic                  o_out_valid,
    input  logic                  i_out_ready,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_overflow
);

    localparam logic [SHAMT_WIDTH-1:0] LAST_STEP = SHAMT_WIDTH'(DATA_WIDTH - 1);

    state_t                  state, state_nxt;
    logic [SHAMT_WIDTH-1:0]  cnt;
    logic [2*DATA_WIDTH-1:0] acc, acc_step;
    logic [DATA_WIDTH-1:0]   a_q, b_q;
    logic [DATA_WIDTH-1:0]   data_q;
    logic                    ovf_q;
    logic [DATA_WIDTH-1:0]   comb_res;
    logic                    comb_ovf;
    logic                    accept, mul_hi_nz;

    alu_mc_comb #(
        .DATA_WIDTH (DATA_WIDTH),
        .OP_WIDTH   (OP_WIDTH),
        .SHAMT_WIDTH(SHAMT_WIDTH)
    ) u_comb (
        .op      (i_op),
        .a       (i_data_a),
        .b       (i_data_b),
        .result  (comb_res),
        .overflow(comb_ovf)
    );

    assign o_in_ready  = (state == S_IDLE);
    assign o_out_valid = (state == S_DONE);
    assign o_data      = data_q;
    assign o_overflow  = ovf_q;
    assign accept      = i_in_valid && o_in_ready;

    // One shift-add step; the final step's sum is what gets registered as the result
    assign acc_step  = b_q[cnt] ? acc + ({{DATA_WIDTH{1'b0}}, a_q} << cnt) : acc;
    assign mul_hi_nz = |acc_step[2*DATA_WIDTH-1:DATA_WIDTH];

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (accept) state_nxt = (i_op == ALU_MUL) ? S_MUL : S_DONE;
            S_MUL:  if (cnt == LAST_STEP) state_nxt = S_DONE;
            S_DONE: if (i_out_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt    <= '0;
            acc    <= '0;
            a_q    <= '0;
            b_q    <= '0;
            data_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        if (i_op == ALU_MUL) begin
                            a_q <= i_data_a;
                            b_q <= i_data_b;
                            cnt <= '0;
                            acc <= '0;
                        end else begin
                            data_q <= comb_res;
                            ovf_q  <= comb_ovf;
                        end
                    end
                end
                S_MUL: begin
                    acc <= acc_step;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST_STEP) begin
`ifdef ALU_MC_SAT_EN
                        data_q <= mul_hi_nz ? '1 : acc_step[DATA_WIDTH-1:0];
`else
                        data_q <= acc_step[DATA_WIDTH-1:0];
`endif
                        ovf_q  <= mul_hi_nz;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
// Directed self-checking bench for alu_mc; expectations follow ALU_MC_SAT_EN when defined.
module tb_alu_mc;

    localparam int DW = 32;
`ifdef ALU_MC_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic          i_clk = 1'b0;
    logic          i_rst_n = 1'b1;
    logic          i_in_valid = 1'b0;
    logic          i_out_ready = 1'b0;
    logic [3:0]    i_op = '0;
    logic [DW-1:0] i_data_a = '0;
    logic [DW-1:0] i_data_b = '0;
    logic          o_in_ready, o_out_valid, o_overflow;
    logic [DW-1:0] o_data;

    int n_tests = 0;
    int n_fail  = 0;

    alu_mc #(.DATA_WIDTH(DW), .OP_WIDTH(4), .SHAMT_WIDTH(5)) dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_in_valid (i_in_valid),
        .o_in_ready (o_in_ready),
        .i_op       (i_op),
        .i_data_a   (i_data_a),
        .i_data_b   (i_data_b),
        .o_out_valid(o_out_valid),
        .i_out_ready(i_out_ready),
        .o_data     (o_data),
        .o_overflow (o_overflow)
    );

    always #5 i_clk = ~i_clk;

    // Issue one op from IDLE; returns cycles from accept edge until o_out_valid (capped)
    task automatic run_op(input logic [3:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                          output int cyc);
        i_op = op; i_data_a = a; i_data_b = b; i_in_valid = 1'b1;
        @(posedge i_clk); #1;
        i_in_valid = 1'b0;
        cyc = 1;
        while (!o_out_valid && cyc < 100) begin
            @(posedge i_clk); #1;
            cyc++;
        end
    endtask

    task automatic take();
        i_out_ready = 1'b1;
        @(posedge i_clk); #1;
        i_out_ready = 1'b0;
    endtask

    task automatic test_reset();
        i_op = 4'd0; i_data_a = 32'd5; i_data_b = 32'd7; i_in_valid = 1'b1;
        #2 i_rst_n = 1'b0;
        repeat (3) @(posedge i_clk);
        @(negedge i_clk) i_rst_n = 1'b1;
        #1;
        n_tests++;
        if (o_in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", o_in_ready); end
        n_tests++;
        if (o_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", o_out_valid); end
        n_tests++;
        if (o_data !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h want 0", o_data); end
        @(posedge i_clk); #1;
        i_in_valid = 1'b0;
        n_tests++;
        if (o_out_valid !== 1'b1 || o_data !== 32'd12 || o_overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL first_add: got v=%b d=%h o=%b want v=1 d=0000000c o=0", o_out_valid, o_data, o_overflow);
        end
        take();
    endtask

    task automatic test_single_cycle_ops();
        logic [3:0]    v_op  [14] = '{4'd0, 4'd1, 4'd1, 4'd0, 4'd2, 4'd3, 4'd4,
                                      4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd9, 4'd11};
        logic [DW-1:0] v_a   [14] = '{32'h7FFFFFFF, 32'h80000000, 32'd5, 32'hFFFFFFFF,
                                      32'hF0F0F0F0, 32'hF0F0F0F0, 32'hF0F0F0F0,
                                      32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1, 32'hF0000000,
                                      32'hF0000000, 32'h70000000, 32'h7FFFFFFF};
        logic [DW-1:0] v_b   [14] = '{32'd1, 32'd1, 32'd7, 32'd1,
                                      32'hFF00FF00, 32'hFF00FF00, 32'hFF00FF00,
                                      32'd1, 32'd1, 32'd33, 32'd4, 32'd4, 32'd4, 32'd1};
        logic [DW-1:0] v_wrap[14] = '{32'h80000000, 32'h7FFFFFFF, 32'hFFFFFFFE, 32'h0,
                                      32'hF000F000, 32'hFFF0FFF0, 32'h0FF00FF0,
                                      32'd1, 32'd0, 32'd2, 32'h0F000000,
                                      32'hFF000000, 32'h07000000, 32'h0};
        logic [DW-1:0] v_sat [14] = '{32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFE, 32'h0,
                                      32'hF000F000, 32'hFFF0FFF0, 32'h0FF00FF0,
                                      32'd1, 32'd0, 32'd2, 32'h0F000000,
                                      32'hFF000000, 32'h07000000, 32'h0};
        logic          v_ovf [14] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                      1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        int            cyc;
        logic [DW-1:0] exp;
        for (int i = 0; i < 14; i++) begin
            run_op(v_op[i], v_a[i], v_b[i], cyc);
            exp = SAT ? v_sat[i] : v_wrap[i];
            n_tests++;
            if (cyc !== 1) begin n_fail++; $display("FAIL op%0d_latency: got %0d want 1", i, cyc); end
            n_tests++;
            if (o_data !== exp || o_overflow !== v_ovf[i]) begin
                n_fail++;
                $display("FAIL op%0d_result (op=%0d): got d=%h o=%b want d=%h o=%b",
                         i, v_op[i], o_data, o_overflow, exp, v_ovf[i]);
            end
            take();
        end
    endtask

    task automatic test_mul();
        logic [DW-1:0] m_a   [3] = '{32'h00010000, 32'd3,  32'hFFFFFFFF};
        logic [DW-1:0] m_b   [3] = '{32'h00010000, 32'd5,  32'd2};
        logic [DW-1:0] m_wrap[3] = '{32'h0,        32'd15, 32'hFFFFFFFE};
        logic [DW-1:0] m_sat [3] = '{32'hFFFFFFFF, 32'd15, 32'hFFFFFFFF};
        logic          m_ovf [3] = '{1'b1, 1'b0, 1'b1};
        int            cyc;
        logic          busy_ok;
        logic [DW-1:0] exp;
        for (int i = 0; i < 3; i++) begin
            i_op = 4'd10; i_data_a = m_a[i]; i_data_b = m_b[i]; i_in_valid = 1'b1;
            @(posedge i_clk); #1;
            i_in_valid = 1'b0;
            cyc = 1;
            busy_ok = 1'b1;
            while (!o_out_valid && cyc < 100) begin
                if (o_in_ready) busy_ok = 1'b0;
                @(posedge i_clk); #1;
                cyc++;
            end
            exp = SAT ? m_sat[i] : m_wrap[i];
            n_tests++;
            if (cyc !== 33) begin n_fail++; $display("FAIL mul%0d_latency: got %0d want 33", i, cyc); end
            n_tests++;
            if (busy_ok !== 1'b1) begin n_fail++; $display("FAIL mul%0d_in_ready_low: got 1 during multiply want 0", i); end
            n_tests++;
            if (o_data !== exp || o_overflow !== m_ovf[i]) begin
                n_fail++;
                $display("FAIL mul%0d_result: got d=%h o=%b want d=%h o=%b", i, o_data, o_overflow, exp, m_ovf[i]);
            end
            take();
        end
    endtask

    task automatic test_back_to_back();
        int done_cnt = 0;
        i_op = 4'd0; i_data_a = 32'd1; i_data_b = 32'd2;
        i_out_ready = 1'b1; i_in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge i_clk); #1;
            if (o_out_valid) done_cnt++;
        end
        i_in_valid = 1'b0; i_out_ready = 1'b0;
        n_tests++;
        if (done_cnt !== 5) begin n_fail++; $display("FAIL b2b_throughput: got %0d results want 5", done_cnt); end
        n_tests++;
        if (o_data !== 32'd3) begin n_fail++; $display("FAIL b2b_data: got %h want 00000003", o_data); end
        @(posedge i_clk); #1;
    endtask

    task automatic test_backpressure();
        int   cyc;
        logic stable = 1'b1;
        run_op(4'd4, 32'hAAAA5555, 32'h0F0F0F0F, cyc);
        i_op = 4'd0; i_data_a = 32'd1; i_data_b = 32'd1; i_in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge i_clk); #1;
            if (o_data !== 32'hA5A55A5A || o_in_ready !== 1'b0 || o_out_valid !== 1'b1) stable = 1'b0;
        end
        i_in_valid = 1'b0;
        n_tests++;
        if (stable !== 1'b1) begin n_fail++; $display("FAIL bp_hold: got unstable d=%h r=%b v=%b want d=a5a55a5a r=0 v=1", o_data, o_in_ready, o_out_valid); end
        take();
        n_tests++;
        if (o_out_valid !== 1'b0 || o_in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_release: got v=%b r=%b want v=0 r=1", o_out_valid, o_in_ready);
        end
        run_op(4'd0, 32'd2, 32'd3, cyc);
        n_tests++;
        if (cyc !== 1 || o_data !== 32'd5) begin n_fail++; $display("FAIL bp_next_op: got cyc=%0d d=%h want cyc=1 d=00000005", cyc, o_data); end
        take();
    endtask

    task automatic test_reset_mid_mul();
        int   cyc;
        logic no_valid = 1'b1;
        i_op = 4'd10; i_data_a = 32'h00010000; i_data_b = 32'h0000FFFF; i_in_valid = 1'b1;
        @(posedge i_clk); #1;
        i_in_valid = 1'b0;
        repeat (10) @(posedge i_clk);
        #1 i_rst_n = 1'b0;
        #1;
        n_tests++;
        if (o_in_ready !== 1'b1 || o_out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL midmul_async_reset: got r=%b v=%b want r=1 v=0", o_in_ready, o_out_valid);
        end
        @(negedge i_clk) i_rst_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge i_clk); #1;
            if (o_out_valid) no_valid = 1'b0;
        end
        n_tests++;
        if (no_valid !== 1'b1) begin n_fail++; $display("FAIL midmul_no_result: got o_out_valid=1 want 0"); end
        run_op(4'd13, 32'hFFFFFFFF, 32'hFFFFFFFF, cyc);
        n_tests++;
        if (cyc !== 1 || o_data !== 32'h0 || o_overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL illegal_op13: got cyc=%0d d=%h o=%b want cyc=1 d=0 o=0", cyc, o_data, o_overflow);
        end
        take();
    endtask

    initial begin
        test_reset();
        test_single_cycle_ops();
        test_mul();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_mul();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_mc.md
Name: alu_mc

Overview:
- Parametrised multi-cycle integer ALU with valid/ready handshakes on both input and output.
- Adds logic, shift, compare and iterative unsigned-multiply operations to signed ADD/SUB with overflow detection.
- Sits between the instruction decode/control FSM and the register writeback path of the core.
- Holds at most one operation in flight; the result register holds until the consumer accepts it.

Parameters:
- DATA_WIDTH, 32, operand/result width; must be a power of two, at least 8.
- OP_WIDTH, 4, opcode width.
- SHAMT_WIDTH, $clog2(DATA_WIDTH), number of shift-amount bits taken from i_data_b.

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst_n  in  1  reset; asynchronous assert, active-low.
- i_in_valid  in  1  operation request valid.
- o_in_ready  out  1  ALU can accept a request.
- i_op  in  OP_WIDTH  opcode.
- i_data_a  in  DATA_WIDTH  operand A.
- i_data_b  in  DATA_WIDTH  operand B, or shift amount.
- o_out_valid  out  1  result valid.
- i_out_ready  in  1  consumer accepts the result.
- o_data  out  DATA_WIDTH  result.
- o_overflow  out  1  overflow flag for the result.

Behaviour:
- Reset: state=IDLE; o_in_ready=1; o_out_valid=0; o_data=0; o_overflow=0; multiply counter and accumulator cleared. Reset mid-operation aborts the operation; no result is produced.
- Opcodes:
  - 0 ADD, 1 SUB: two's complement; overflow when operands (B inverted for SUB) share a sign that differs from the result sign.
  - 2 AND, 3 OR, 4 XOR.
  - 5 SLT: signed compare, result 1 or 0.
  - 6 SLTU: unsigned compare, result 1 or 0.
  - 7 SLL, 8 SRL, 9 SRA: shift amount = i_data_b[SHAMT_WIDTH-1:0].
  - 10 MUL: unsigned; o_data = low DATA_WIDTH bits of the 2*DATA_WIDTH product; overflow = any high half bit set.
  - 11-15: illegal; o_data=0, o_overflow=0, still completes in one cycle.
- o_overflow is 0 for every op other than ADD, SUB and MUL.
- Handshake:
  - Input transfer on i_in_valid && o_in_ready; operands and opcode are captured on that edge.
  - Output transfer on o_out_valid && i_out_ready.
  - o_in_ready = (state==IDLE); this is a registered decode with no combinational path from the i_ inputs.
- FSM:
  - IDLE, on accept of a non-MUL op -> DONE; result and flag registered on the same edge.
  - IDLE, on accept of MUL -> MUL; count=0, acc=0.
  - MUL: one shift-add step per cycle (if B[count], acc += A<<count); after step DATA_WIDTH-1 -> DONE with the result registered.
  - DONE: o_out_valid=1; o_data and o_overflow held stable until the transfer; on the transfer -> IDLE.
- Latency, accept edge to o_out_valid: 1 cycle for non-MUL ops, DATA_WIDTH+1 cycles for MUL.
- Throughput: one op per 2 cycles for non-MUL ops when i_out_ready is held high. No accept occurs in the cycle a result is taken (no bypass).
- Boundaries:
  - Shift amount uses the low bits only; for DATA_WIDTH=32, B=33 shifts by 1.
  - SRA of a negative value fills with ones.
  - SUB of the most negative value: 0x80000000-1 flags overflow.
  - Input lines are ignored outside IDLE, even if i_in_valid is held.
  - Output stall of any length is legal; there is no timeout.

Optional Feature:
- Macro: ALU_MC_SAT_EN.
- When defined: ADD and SUB saturate on overflow. Result is 0x7F..F on positive overflow and 0x80..0 on negative overflow; o_overflow still reports 1.
- When defined: MUL saturates to all-ones when the high half is non-zero.
- When undefined: wrap-around results; overflow flag only.

Decomposition:
- Shared package alu_pkg:
  - opcode localparams ALU_ADD..ALU_MUL;
  - FSM state encodings S_IDLE, S_MUL, S_DONE;
  - OP_WIDTH.
- Sub-module alu_mc_comb: purely combinational; computes every single-cycle op result and its overflow.
- alu_mc contains the FSM, handshake registers and the iterative multiplier datapath.

Test Plan:
- Reset with i_in_valid=1 held: after i_rst_n rises, o_in_ready=1, o_out_valid=0, o_data=0. After de-assert, first accepted ADD 5+7 -> o_data=12, o_overflow=0 one cycle later.
- ADD 0x7FFFFFFF+1 -> 0x80000000, overflow=1. With ALU_MC_SAT_EN -> 0x7FFFFFFF, overflow=1. SUB 0x80000000-1 -> 0x7FFFFFFF, overflow=1.
- Shifts:
  - SRA 0xF0000000 by B=4 -> 0xFF000000.
  - SRL same operands -> 0x0F000000.
  - SLL 1 by B=33 -> 2.
  - SLT 0xFFFFFFFF,1 -> 1; SLTU same operands -> 0.
- MUL 0x10000 x 0x10000:
  - o_in_ready low for the multiply;
  - o_out_valid 33 cycles after accept;
  - o_data=0, o_overflow=1; with the macro, o_data=0xFFFFFFFF.
- Backpressure: hold i_out_ready=0 for 10 cycles after an XOR result. o_data stays stable, o_in_ready stays 0 and a new i_in_valid is ignored. Release -> transfer, then the next op is accepted.
- Assert i_rst_n=0 mid-MUL (count=10): state returns to IDLE asynchronously and no o_out_valid occurs. Then opcode 13 -> o_data=0, o_overflow=0 after 1 cycle.
